spi_xfer_sequencer: RTL and testbench
=====================================

# spi_xfer_sequencer

Word-stream front end for the single SPI master. Buffers outgoing words in a TX FIFO and issues one `spi_start` per word with the data held stable. It waits for the master's `spi_done` and pushes each received word into an RX FIFO with a valid/ready output. It sits directly upstream of the SPI master, between it and the system-side producer/consumer.

## Interface
- `WIDTH`, 8: SPI word length; must equal the master's `WIDTH`.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `GAP`, 2: idle clk cycles inserted after each transfer; 0 allowed.
- `TIMEOUT`, 64: watchdog limit in clk cycles; used only with `SPI_SEQ_TIMEOUT_EN`.
- `clk`  in  1  clock.
- `reset`  in  1  reset; asynchronous, active-high.
- `tx_valid`  in  1  producer word valid.
- `tx_ready`  out  1  TX FIFO not full.
- `tx_data`  in  WIDTH  word to send.
- `rx_valid`  out  1  RX FIFO not empty.
- `rx_ready`  in  1  consumer pop.
- `rx_data`  out  WIDTH  RX FIFO head (first-word-fall-through).
- `tx_level`  out  clog2(DEPTH)+1  TX FIFO occupancy.
- `busy`  out  1  FSM not in IDLE, or TX FIFO non-empty.
- `err`  out  1  sticky timeout flag.
- `spi_start`  out  1  one-cycle start pulse to the master.
- `spi_tx_data`  out  WIDTH  word for the master; registered, held until the next start.
- `spi_rx_data`  in  WIDTH  master receive word.
- `spi_done`  in  1  master completion pulse.

## Operation
- Handshakes:
  - TX push when `tx_valid & tx_ready`.
  - RX pop when `rx_valid & rx_ready`.
  - `tx_ready = !tx_full`. A push into a full TX FIFO is refused even if a pop happens in the same cycle.
  - RX push and pop in the same cycle are both performed; the level is unchanged.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE→START when the TX FIFO is non-empty and RX level < DEPTH. A slot is reserved before launch, so the RX FIFO never overflows. On this edge, register `spi_tx_data <= tx head`, pop the TX FIFO, and set `spi_start <= 1`.
  - START→WAIT unconditionally. `spi_start` is 1 only in START.
  - WAIT→GAP on `spi_done` (→IDLE directly if GAP==0). On this edge, push `spi_rx_data` into the RX FIFO. Any `spi_done` outside WAIT is ignored.
  - GAP: down-counter loaded with GAP−1; →IDLE when it reaches 0.
- Reset values: `spi_start`=0, `spi_tx_data`=0, `rx_valid`=0, `rx_data`=0, `tx_ready`=1, `tx_level`=0, `busy`=0, `err`=0. The FSM is in IDLE and both FIFOs are empty.
- Reset mid-transfer aborts immediately and nothing is pushed. The master shares the same reset.
- FIFO pointers are clog2(DEPTH) bits and wrap naturally. Occupancy counters are one bit wider.

## Timing
- A TX handshake at edge N while IDLE with an empty pipe gives `spi_start` high in cycle N+2, with `spi_tx_data` valid in the same cycle.
- `spi_done` sampled at edge D gives `rx_valid` high from D+1, assuming the RX FIFO was empty.
- The next `spi_start` rises exactly GAP+2 cycles after the `spi_done` cycle, provided TX is non-empty and RX has space.
- The transfer period is (master latency) + GAP + 2 cycles. There are no back-to-back starts.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined:
  - WAIT runs a cycle counter.
  - If `spi_done` has not arrived TIMEOUT cycles after entering WAIT, the FSM goes →IDLE, no RX push occurs, the RX slot reservation is released, and `err` is set.
  - `err` stays set until reset.
- Undefined:
  - No counter is built.
  - WAIT waits indefinitely.
  - `err` is tied to 0.

## Structure
- Package `spi_seq_pkg` holds:
  - the `state_t` enum (IDLE, START, WAIT, GAP);
  - the `clog2` function;
  - the default-parameter constants.
- Sub-module `spi_seq_fifo`:
  - synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH;
  - outputs: full, empty, level;
  - instantiated twice (TX, RX).

## Test plan
All scenarios use WIDTH=8, DEPTH=4, GAP=2, with a master model that returns a programmed word and pulses `spi_done` 9 cycles after start.
- Single word: push 0xA5, model returns 0x3C → one `spi_start` with `spi_tx_data`=0xA5. `rx_data`=0x3C and `rx_valid` rise the cycle after `spi_done`. `busy` falls 3 cycles after `spi_done`.
- Backpressure: push 0x01..0x06 with `rx_ready`=0 → exactly 4 starts. The 5th start occurs only after one RX pop. RX order is preserved.
- Gap check: 3 queued words → each `spi_start` is exactly 4 cycles after the preceding `spi_done`. With GAP=0 the spacing is 2 cycles.
- TX full: `spi_done` held low, 5 pushes → the first word launches, the TX FIFO then accepts 4 more, `tx_ready`=0 and `tx_level`=4, and later pushes are refused.
- Reset in WAIT: assert reset 3 cycles after `spi_start` → all outputs return to reset values, and a later stray `spi_done` pushes nothing.
- With `SPI_SEQ_TIMEOUT_EN` and TIMEOUT=32: `spi_done` never pulses → `err`=1 32 cycles after entering WAIT, the FSM returns to IDLE, RX stays empty, and the next queued word launches. Without the macro, `busy` stays 1 indefinitely.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared state encoding, default parameters and clog2 for the SPI sequencer
package spi_seq_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// rtl/spi_seq_fifo.sv - synchronous first-word-fall-through FIFO with full/empty/level
module spi_seq_fifo
  import spi_seq_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/spi_xfer_sequencer.sv
// rtl/spi_xfer_sequencer.sv - TX/RX word FIFOs around the SPI master; SPI_SEQ_TIMEOUT_EN adds a WAIT watchdog
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int DEPTH   = DEF_DEPTH,
  parameter  int GAP     = DEF_GAP,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int LW      = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic [LW-1:0]    tx_level,
  output logic             busy,
  output logic             err,
  output logic             spi_start,
  output logic [WIDTH-1:0] spi_tx_data,
  input  logic [WIDTH-1:0] spi_rx_data,
  input  logic             spi_done
);

  localparam int GW = clog2(GAP + 2);

  state_t           state, state_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             tx_full, tx_empty, tx_pop;
  logic [WIDTH-1:0] tx_head;
  logic             rx_empty, rx_push, rx_full_unused;
  logic [LW-1:0]    rx_level;

  spi_seq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_valid),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  spi_seq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (spi_rx_data),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full_unused),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign busy     = (state != S_IDLE) || !tx_empty;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          err_q;
  logic          timed_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (state == S_WAIT) ? wait_cnt + TW'(1) : '0;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  localparam int timeout_unused = TIMEOUT;
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    timed_out = 1'b0;
`endif
    case (state)
      // Launch only with an RX slot free; the one transfer in flight owns it.
      S_IDLE: begin
        if (!tx_empty && (rx_level < LW'(DEPTH))) begin
          tx_pop  = 1'b1;
          state_n = S_START;
        end
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (spi_done) begin
          rx_push = 1'b1;
          if (GAP == 0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_GAP;
            gap_n   = GW'(GAP - 1);
          end
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          state_n   = S_IDLE;
          timed_out = 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_IDLE;
        else               gap_n   = gap_cnt - GW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      spi_start   <= 1'b0;
      spi_tx_data <= '0;
    end else begin
      state     <= state_n;
      gap_cnt   <= gap_n;
      spi_start <= (state_n == S_START);
      if (tx_pop) spi_tx_data <= tx_head;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// tb/tb_spi_xfer_sequencer.sv - directed self-checking bench for spi_xfer_sequencer (GAP=2 and GAP=0)
module tb_spi_xfer_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0, rx_ready = 1'b0, spi_done = 1'b0;
  logic [7:0] tx_data = '0, spi_rx_data = '0;
  logic       tx_ready, rx_valid, busy, err, spi_start;
  logic [7:0] rx_data, spi_tx_data;
  logic [2:0] tx_level;

  logic       tx_valid0 = 1'b0, rx_ready0 = 1'b0, spi_done0 = 1'b0;
  logic [7:0] tx_data0 = '0, spi_rx_data0 = '0;
  logic       tx_ready0, rx_valid0, busy0, err0, spi_start0;
  logic [7:0] rx_data0, spi_tx_data0;
  logic [2:0] tx_level0;

  int n_assert = 0, n_fail = 0, cyc = 0;
  int n_starts = 0, last_done = 0, m_cnt = 0, spacing[16];
  int n_starts0 = 0, last_done0 = 0, m_cnt0 = 0, spacing0[16];
  logic       model_en = 1'b1;
  logic [7:0] model_xor = 8'h00;

  spi_xfer_sequencer #(.WIDTH(8), .DEPTH(4), .GAP(2), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .tx_level(tx_level),
    .busy(busy), .err(err), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
    .spi_rx_data(spi_rx_data), .spi_done(spi_done)
  );

  spi_xfer_sequencer #(.WIDTH(8), .DEPTH(4), .GAP(0), .TIMEOUT(32)) dut0 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_data(tx_data0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_data(rx_data0), .tx_level(tx_level0),
    .busy(busy0), .err(err0), .spi_start(spi_start0), .spi_tx_data(spi_tx_data0),
    .spi_rx_data(spi_rx_data0), .spi_done(spi_done0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master models: spi_done pulses in the 9th cycle after the start cycle.
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (spi_start) begin
      n_starts++;
      if (n_starts < 16) spacing[n_starts] = cyc - last_done;
      m_cnt = 9;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && model_en) begin
        spi_done    = 1'b1;
        spi_rx_data = spi_tx_data ^ model_xor;
        last_done   = cyc;
      end
    end
  end

  always @(negedge clk) begin
    spi_done0 = 1'b0;
    if (spi_start0) begin
      n_starts0++;
      if (n_starts0 < 16) spacing0[n_starts0] = cyc - last_done0;
      m_cnt0 = 9;
    end else if (m_cnt0 > 0) begin
      m_cnt0--;
      if (m_cnt0 == 0) begin
        spi_done0    = 1'b1;
        spi_rx_data0 = spi_tx_data0;
        last_done0   = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 200) begin
      step(1);
      n++;
    end
    step(1);
    tx_valid = 1'b0;
    check("push_bound", 32'(n < 200), 1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rx_data, exp);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, spi_start, 0);
    check({tag, "_spi_tx"}, spi_tx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_tx_level"}, tx_level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    int n;

    step(2);
    check_reset_values("rst");
    reset = 1'b0;
    step(2);

    // Single word: A5 out, 3C back.
    model_xor = 8'h99;
    tx_data   = 8'hA5;
    tx_valid  = 1'b1;
    step(1);
    tx_valid  = 1'b0;
    check("single_level", tx_level, 1);
    check("single_no_start_yet", spi_start, 0);
    step(1);
    check("single_start", spi_start, 1);
    check("single_spi_tx", spi_tx_data, 8'hA5);
    n = 0;
    while (!spi_done && n < 30) begin
      step(1);
      n++;
    end
    check("single_done_bound", 32'(n < 30), 1);
    check("single_rx_before", rx_valid, 0);
    step(1);
    check("single_rx_valid", rx_valid, 1);
    check("single_rx_data", rx_data, 8'h3C);
    step(1);
    check("single_busy_d2", busy, 1);
    step(1);
    check("single_busy_d3", busy, 0);
    check("single_starts", n_starts, 1);
    pop_check("single_pop", 8'h3C);
    check("single_rx_empty", rx_valid, 0);

    // Backpressure: RX holds 4, 5th start only after a pop.
    model_xor = 8'h00;
    n_starts  = 0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    step(120);
    check("bp_starts4", n_starts, 4);
    check("bp_tx_level", tx_level, 2);
    pop_check("bp_pop1", 8'h01);
    step(20);
    check("bp_starts5", n_starts, 5);
    pop_check("bp_pop2", 8'h02);
    pop_check("bp_pop3", 8'h03);
    pop_check("bp_pop4", 8'h04);
    pop_check("bp_pop5", 8'h05);
    step(40);
    pop_check("bp_pop6", 8'h06);
    check("bp_starts6", n_starts, 6);
    check("bp_rx_empty", rx_valid, 0);

    // Gap spacing, GAP=2 then GAP=0.
    n_starts = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step(60);
    check("gap2_starts", n_starts, 3);
    check("gap2_space2", spacing[2], 4);
    check("gap2_space3", spacing[3], 4);
    pop_check("gap2_pop1", 8'h11);
    pop_check("gap2_pop2", 8'h22);
    pop_check("gap2_pop3", 8'h33);

    tx_valid0 = 1'b1;
    tx_data0  = 8'h44;
    step(1);
    tx_data0  = 8'h55;
    step(1);
    tx_data0  = 8'h66;
    step(1);
    tx_valid0 = 1'b0;
    step(60);
    check("gap0_starts", n_starts0, 3);
    check("gap0_space2", spacing0[2], 2);
    check("gap0_space3", spacing0[3], 2);
    check("gap0_rx_head", rx_data0, 8'h44);

    // TX full with spi_done held low.
    model_en = 1'b0;
    n_starts = 0;
    for (int i = 0; i < 5; i++) push(8'h81 + 8'(i));
    check("full_tx_ready", tx_ready, 0);
    check("full_tx_level", tx_level, 4);
    check("full_starts", n_starts, 1);
    check("full_spi_tx", spi_tx_data, 8'h81);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    step(3);
    tx_valid = 1'b0;
    check("full_refused", tx_level, 4);
    step(100);
`ifdef SPI_SEQ_TIMEOUT_EN
    check("timeout_err", err, 1);
    check("timeout_rx_empty", rx_valid, 0);
    check("timeout_relaunch", 32'(n_starts > 1), 1);
`else
    check("stuck_busy", busy, 1);
    check("stuck_err", err, 0);
    check("stuck_starts", n_starts, 1);
`endif
    reset = 1'b1;
    #1;
    check_reset_values("full_rst");
    step(2);
    reset = 1'b0;
    step(2);

    // Reset three cycles into a transfer; the later spi_done is stray.
    model_en = 1'b1;
    n_starts = 0;
    push(8'h5A);
    n = 0;
    while (!spi_start && n < 10) begin
      step(1);
      n++;
    end
    check("rw_start_bound", 32'(n < 10), 1);
    step(3);
    reset = 1'b1;
    #1;
    check_reset_values("rw_rst");
    step(2);
    reset = 1'b0;
    step(15);
    check("rw_stray_rx", rx_valid, 0);
    check("rw_stray_busy", busy, 0);
    check("rw_stray_starts", n_starts, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
